fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 64, PC and i$ address width.
REQ-002 Parameter DEPTH, default 4, instruction-queue entries; power of two, 2..16.
REQ-003 Parameter PC_INIT, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 imem_req_valid  output  1  fetch request pending.
REQ-007 imem_req_ready  input  1  i$ accepts the request this cycle.
REQ-008 imem_req_addr  output  ADDR_W  fetch address, bits [1:0] always 0.
REQ-009 imem_rsp_valid  input  1  i$ returns one instruction; responses arrive in request order, latency >= 1.
REQ-010 imem_rsp_inst  input  32  returned instruction.
REQ-011 out_valid  output  1  queue head valid to decode.
REQ-012 out_ready  input  1  decode consumes the head.
REQ-013 out_pc  output  ADDR_W  PC of the head instruction.
REQ-014 out_inst  output  32  head instruction.
REQ-015 redirect_valid  input  1  taken branch or flush from execute.
REQ-016 redirect_pc  input  ADDR_W  new fetch PC; bits [1:0] are ignored and treated as 0.
REQ-017 occupancy  output  $clog2(DEPTH)+1  current queue entry count.

Function
REQ-018 Fetch PC (fpc) advances by 4 on each request handshake (imem_req_valid & imem_req_ready), modulo 2^ADDR_W.
REQ-019 imem_req_valid = !rst & !redirect_valid & (occupancy + outstanding < DEPTH); credits guarantee every response has a queue slot.
REQ-020 outstanding counter: +1 on request handshake, -1 on imem_rsp_valid, both in the same cycle gives no net change.
REQ-021 Response PC register (rpc) tags each accepted response; rpc advances by 4 per accepted response.
REQ-022 Queue is a FIFO of {pc, inst}; a non-stale response is written the cycle it arrives, and out_valid rises the next cycle (1-cycle latency, i$ response to decode).
REQ-023 Head is removed on out_valid & out_ready; enqueue and dequeue in the same cycle keep occupancy unchanged, even when full.
REQ-024 On redirect_valid: queue is flushed, fpc and rpc load redirect_pc & ~3, drop counter loads (outstanding + request handshake this cycle - response this cycle).
REQ-025 While the drop counter is non-zero, each imem_rsp_valid is discarded and decrements it; responses are not written into the queue.
REQ-026 A response arriving in the redirect cycle is discarded.
REQ-027 A decode handshake in the redirect cycle completes for the old head, then the flush takes effect; out_valid is 0 the following cycle.
REQ-028 Back-to-back redirects: the last redirect wins, and the drop counts accumulate correctly.
REQ-029 Full queue: no new requests; empty queue: out_valid = 0, out_pc and out_inst hold their last values.
REQ-030 imem_rsp_valid with outstanding = 0 is a protocol error; it is ignored, and an assertion flags it.

Reset
REQ-031 On rst: fpc = rpc = PC_INIT, occupancy = outstanding = drop = 0, imem_req_valid = 0, out_valid = 0, out_pc = PC_INIT, out_inst = 0.
REQ-032 Mid-operation reset discards queue contents and in-flight responses; the first request (addr PC_INIT) is issued the first cycle after rst deasserts.

Structure
REQ-033 Shared package cpu_pkg holds INST_W = 32, PC_INIT default, PC_STEP = 4, and the queue-entry struct {pc, inst}.
REQ-034 The queue is one sub-module, sync_fifo (WIDTH, DEPTH, flush input); fetch_unit holds the counters, fpc and rpc.

Verification
REQ-035 Reset release, i$ latency 1, out_ready = 1 -> requests 0, 4, 8, ... one per cycle; out_pc sequence 0, 4, 8 with matching out_inst.
REQ-036 out_ready = 0, DEPTH = 4 -> exactly 4 requests issued, occupancy = 4, imem_req_valid = 0 until the first dequeue.
REQ-037 Redirect to 0x1002 with 2 responses outstanding -> both dropped, next request addr 0x1000, first out_pc = 0x1000.
REQ-038 Redirect in the same cycle as rsp_valid and a decode handshake -> head consumed, response discarded, out_valid = 0 next cycle.
REQ-039 ADDR_W = 8, fpc = 0xFC -> next request addr 0x00.
REQ-040 rst asserted with 3 entries queued and 2 outstanding -> outputs at reset values immediately; first post-reset out_pc = PC_INIT.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path constants and the instruction-queue entry type
package cpu_pkg;
   localparam int INST_W   = 32;
   localparam int PC_MAX_W = 64;
   localparam int PC_STEP  = 4;
   localparam logic [PC_MAX_W-1:0] PC_INIT_DEFAULT = '0;

   // pc is sized for the widest supported ADDR_W; narrower PCs are zero-extended
   typedef struct packed {
      logic [PC_MAX_W-1:0] pc;
      logic [INST_W-1:0]   inst;
   } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; the head output holds its last value when empty
module sync_fifo #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_valid,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             do_wr, do_rd;

   assign rd_valid = (count_q != '0);
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : hold_q;
   assign count    = count_q;
   assign do_rd    = rd_valid & rd_ready;
   assign do_wr    = wr_valid & ~flush & ((count_q != (AW+1)'(DEPTH)) | do_rd);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hold_d   = rd_valid ? mem_q[rd_ptr_q] : hold_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= RST_DATA;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-based instruction fetch with redirect flush and stale-response dropping
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W  = 64,
   parameter int                DEPTH   = 4,
   parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_INIT_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [ADDR_W-1:0]      imem_req_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INST_W-1:0]      imem_rsp_inst,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [INST_W-1:0]      out_inst,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int                CW         = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam fetch_entry_t      RST_ENTRY  = '{pc: PC_MAX_W'(PC_INIT), inst: '0};

   logic [ADDR_W-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
   logic [CW-1:0]     outst_q, outst_d, drop_q, drop_d;
   logic [CW:0]       credit_used;
   logic              req_hs, rsp_acc, rsp_keep;
   fetch_entry_t      wr_entry, rd_entry;
   logic              unused_pc_hi;

   // Every in-flight request owns a queue slot, so a kept response can always be written
   assign credit_used    = {1'b0, occupancy} + {1'b0, outst_q};
   assign imem_req_valid = ~rst & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
   assign imem_req_addr  = fpc_q;
   assign req_hs         = imem_req_valid & imem_req_ready;
   assign rsp_acc        = imem_rsp_valid & (outst_q != '0);
   assign rsp_keep       = rsp_acc & ~redirect_valid & (drop_q == '0);

   always_comb begin
      fpc_d   = fpc_q;
      rpc_d   = rpc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      case ({req_hs, rsp_acc})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
      if (req_hs)   fpc_d = fpc_q + STEP;
      if (rsp_keep) rpc_d = rpc_q + STEP;
      if (rsp_acc && !redirect_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      // Everything still in flight after this edge belongs to the old path
      if (redirect_valid) begin
         fpc_d  = redirect_pc & ALIGN_MASK;
         rpc_d  = redirect_pc & ALIGN_MASK;
         drop_d = outst_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_q   <= PC_INIT;
         rpc_q   <= PC_INIT;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         fpc_q   <= fpc_d;
         rpc_q   <= rpc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.pc   = PC_MAX_W'(rpc_q);
      wr_entry.inst = imem_rsp_inst;
   end

   sync_fifo #(
      .WIDTH    ($bits(fetch_entry_t)),
      .DEPTH    (DEPTH),
      .RST_DATA (RST_ENTRY)
   ) u_iq (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .wr_valid (rsp_keep),
      .wr_data  (wr_entry),
      .rd_ready (out_ready),
      .rd_valid (out_valid),
      .rd_data  (rd_entry),
      .count    (occupancy)
   );

   assign out_pc       = rd_entry.pc[ADDR_W-1:0];
   assign out_inst     = rd_entry.inst;
   // Upper pc bits are always zero when ADDR_W is narrower than the entry field
   assign unused_pc_hi = ^rd_entry.pc;

   rsp_without_request: assert property (@(posedge clk) disable iff (rst)
      !(imem_rsp_valid && (outst_q == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against a queue-level reference model
module tb_fetch_unit;
   localparam int          DEPTH   = 4;
   localparam logic [63:0] PC_INIT = 64'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_ready, imem_rsp_valid, out_ready, redirect_valid;
   logic [31:0] imem_rsp_inst;
   logic [63:0] redirect_pc;

   logic        imem_req_valid, out_valid;
   logic [63:0] imem_req_addr, out_pc;
   logic [31:0] out_inst;
   logic [2:0]  occupancy;

   logic        n_req_valid, n_out_valid;
   logic [7:0]  n_req_addr, n_out_pc;
   logic [31:0] n_out_inst;
   logic [2:0]  n_occupancy;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(64), .DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .occupancy(occupancy)
   );

   fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .PC_INIT(8'h00)) dut8 (
      .clk(clk), .rst(rst),
      .imem_req_valid(n_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(n_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc), .out_inst(n_out_inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc[7:0]), .occupancy(n_occupancy)
   );

   typedef struct { logic [63:0] addr; int epoch; int due; } pend_t;
   typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

   pend_t       pend_q[$];
   ent_t        mq[$];
   logic [63:0] exp_fpc, last_pc;
   logic [31:0] last_inst;
   int          epoch, cyc, n_checks, n_pass, n_fail;
   int          lat_max, rdy_pct, req_pct, rsp_pct;
   bit          hold_rsp;
   logic        smp_req_valid, smp_hs, smp_out_valid;
   logic [63:0] smp_req_addr, smp_out_pc;
   logic [31:0] smp_out_inst;
   logic [7:0]  smp_req_addr8;
   logic [2:0]  smp_occ;

   function automatic logic [31:0] imem(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      pend_q.delete();
      exp_fpc   = PC_INIT;
      last_pc   = PC_INIT;
      last_inst = 32'h0;
      epoch++;
   endtask

   // One clock cycle: drive at the negedge, check 1 time unit later, advance the model.
   task automatic step(input bit redir, input logic [63:0] tgt);
      bit    exp_rv, exp_ov, req_hs, deq, rsp;
      ent_t  e;
      pend_t p;
      redirect_valid = redir;
      redirect_pc    = tgt;
      out_ready      = ($urandom_range(99) < rdy_pct);
      imem_req_ready = ($urandom_range(99) < req_pct);
      rsp = !hold_rsp && (pend_q.size() > 0) && ($urandom_range(99) < rsp_pct);
      if (rsp) rsp = (pend_q[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_inst  = rsp ? imem(pend_q[0].addr) : $urandom;
      #1;
      smp_req_valid = imem_req_valid;
      smp_req_addr  = imem_req_addr;
      smp_req_addr8 = n_req_addr;
      smp_hs        = imem_req_valid & imem_req_ready;
      smp_out_valid = out_valid;
      smp_out_pc    = out_pc;
      smp_out_inst  = out_inst;
      smp_occ       = occupancy;

      exp_ov = (mq.size() > 0);
      exp_rv = !redir && (mq.size() + pend_q.size() < DEPTH);
      chk("out_valid", out_valid, exp_ov);
      chk("out_valid8", n_out_valid, exp_ov);
      chk("occupancy", occupancy, mq.size());
      chk("occupancy8", n_occupancy, mq.size());
      chk("req_valid", imem_req_valid, exp_rv);
      chk("req_valid8", n_req_valid, exp_rv);
      if (exp_rv) begin
         chk("req_addr", imem_req_addr, exp_fpc);
         chk("req_addr8", n_req_addr, exp_fpc[7:0]);
      end
      if (exp_ov) e = mq[0];
      else begin
         e.pc   = last_pc;
         e.inst = last_inst;
      end
      chk("out_pc", out_pc, e.pc);
      chk("out_inst", out_inst, e.inst);
      chk("out_pc8", n_out_pc, e.pc[7:0]);
      chk("out_inst8", n_out_inst, e.inst);
      last_pc   = e.pc;
      last_inst = e.inst;

      req_hs = exp_rv && imem_req_ready;
      deq    = exp_ov && out_ready;
      if (deq) void'(mq.pop_front());
      if (rsp) begin
         p = pend_q.pop_front();
         if (!redir && (p.epoch == epoch)) begin
            e.pc   = p.addr;
            e.inst = imem(p.addr);
            mq.push_back(e);
         end
      end
      if (req_hs) begin
         p.addr  = exp_fpc;
         p.epoch = epoch;
         p.due   = cyc + 1 + int'($urandom_range(lat_max - 1));
         pend_q.push_back(p);
         exp_fpc = exp_fpc + 64'd4;
      end
      if (redir) begin
         mq.delete();
         epoch++;
         exp_fpc = tgt & ~64'h3;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain();
      rdy_pct  = 100;
      req_pct  = 0;
      rsp_pct  = 100;
      hold_rsp = 0;
      repeat (8) step(1'b0, 64'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_pc"}, out_pc, PC_INIT);
      chk({tag, "_out_inst"}, out_inst, 32'h0);
      chk({tag, "_occupancy"}, occupancy, 3'd0);
      chk({tag, "_out_valid8"}, n_out_valid, 1'b0);
      chk({tag, "_out_pc8"}, n_out_pc, 8'h00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  found;
      logic [63:0] tgt;
      n_checks = 0; n_pass = 0; n_fail = 0; epoch = 0; cyc = 0;
      lat_max = 1; rdy_pct = 100; req_pct = 100; rsp_pct = 100; hold_rsp = 0;
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_inst = '0;
      out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Streaming with latency 1: one request per cycle, decode sees 0, 4, 8 ...
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 64'h0);
         chk("r35_req_valid", smp_req_valid, 1'b1);
         chk("r35_req_addr", smp_req_addr, 64'(4 * i));
         if (i >= 2) begin
            chk("r35_out_valid", smp_out_valid, 1'b1);
            chk("r35_out_pc", smp_out_pc, 64'(4 * (i - 2)));
            chk("r35_out_inst", smp_out_inst, imem(64'(4 * (i - 2))));
         end
      end

      // Decode stalled: exactly DEPTH requests, then no more until a dequeue
      drain();
      rdy_pct = 0; req_pct = 100; n = 0;
      repeat (10) begin
         step(1'b0, 64'h0);
         if (smp_hs) n++;
      end
      chk("r36_requests", n, DEPTH);
      chk("r36_occupancy", smp_occ, 3'd4);
      chk("r36_req_valid", smp_req_valid, 1'b0);
      rdy_pct = 100;
      repeat (3) step(1'b0, 64'h0);

      // Redirect with two responses outstanding
      drain();
      hold_rsp = 1; req_pct = 100; found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (pend_q.size() == 2) found = 1;
         else step(1'b0, 64'h0);
      end
      chk("r37_two_outstanding", found, 1'b1);
      step(1'b1, 64'h1002);
      hold_rsp = 0;
      step(1'b0, 64'h0);
      chk("r37_req_valid", smp_req_valid, 1'b1);
      chk("r37_req_addr", smp_req_addr, 64'h1000);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 64'h0);
         found = smp_out_valid;
      end
      chk("r37_out_seen", found, 1'b1);
      chk("r37_first_out_pc", smp_out_pc, 64'h1000);

      // Redirect coinciding with a response and a decode handshake
      drain();
      rdy_pct = 0; req_pct = 100;
      repeat (2) step(1'b0, 64'h0);
      hold_rsp = 1; found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (pend_q.size() > 0 && mq.size() > 0) found = 1;
         else step(1'b0, 64'h0);
      end
      chk("r38_setup", found, 1'b1);
      hold_rsp = 0; rdy_pct = 100;
      step(1'b1, 64'h2000);
      chk("r38_head_valid", smp_out_valid, 1'b1);
      step(1'b0, 64'h0);
      chk("r38_out_valid_after", smp_out_valid, 1'b0);

      // Address wrap in the 8-bit instance
      req_pct = 100;
      step(1'b1, 64'hFC);
      n = 0;
      for (int i = 0; i < 20 && n < 2; i++) begin
         step(1'b0, 64'h0);
         if (smp_hs) begin
            chk((n == 0) ? "r39_addr8_fc" : "r39_addr8_wrap", smp_req_addr8, (n == 0) ? 8'hFC : 8'h00);
            n++;
         end
      end
      chk("r39_two_requests", n, 2);

      // Mid-operation reset with entries queued and requests outstanding
      drain();
      rdy_pct = 0; req_pct = 100;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b0, 64'h0);
         if (mq.size() >= 2 && pend_q.size() >= 1) found = 1;
      end
      chk("r40_setup", found, 1'b1);
      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
      #1;
      check_reset_outputs("r40_reset");
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rdy_pct = 100;
      step(1'b0, 64'h0);
      chk("r40_first_req_valid", smp_req_valid, 1'b1);
      chk("r40_first_req_addr", smp_req_addr, PC_INIT);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1'b0, 64'h0);
         found = smp_out_valid;
      end
      chk("r40_out_seen", found, 1'b1);
      chk("r40_first_out_pc", smp_out_pc, PC_INIT);

      // Randomized traffic with variable latency and random redirects
      lat_max = 4; rdy_pct = 60; req_pct = 70; rsp_pct = 70;
      for (int i = 0; i < 1500; i++) begin
         tgt = {$urandom, $urandom};
         case ($urandom_range(2))
            0:       tgt[63:6] = '1;
            1:       tgt[63:12] = '0;
            default: ;
         endcase
         step($urandom_range(99) < 4, tgt);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
